pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen_pkg.sv | 44 ++++
 rtl/pattern_gen_bars.sv | 26 ++
 rtl/pattern_gen.sv | 149 ++++++++++++++
 tb/tb_pattern_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// rtl/pattern_gen_pkg.sv - mode encodings, colour constants and bar colour table
package pattern_gen_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_CYCLE    = 3'd1,
    MODE_BARS     = 3'd2,
    MODE_CHECKER  = 3'd3,
    MODE_GRADIENT = 3'd4,
    MODE_SCROLL   = 3'd5,
    MODE_BLACK6   = 3'd6,
    MODE_BLACK7   = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    CYC_RED   = 2'd0,
    CYC_GREEN = 2'd1,
    CYC_BLUE  = 2'd2
  } cyc_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Classic colour-bar order, left to right.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = RGB_WHITE;
      3'd1:    bar_rgb = RGB_YELLOW;
      3'd2:    bar_rgb = RGB_CYAN;
      3'd3:    bar_rgb = RGB_GREEN;
      3'd4:    bar_rgb = RGB_MAGENTA;
      3'd5:    bar_rgb = RGB_RED;
      3'd6:    bar_rgb = RGB_BLUE;
      default: bar_rgb = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/pattern_gen_bars.sv
// rtl/pattern_gen_bars.sv - column to colour-bar mapping via a constant compare chain
module pattern_gen_bars
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int XW       = 10
) (
  input  logic [XW-1:0] col,
  output logic [23:0]   rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] idx;

  // Counting crossed bar boundaries saturates naturally at 7.
  always_comb begin
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (32'(col) >= 32'(k * BAR_W)) idx = 3'(k);
    end
  end

  assign rgb = bar_rgb(idx);

endmodule

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - test pattern generator: one registered pixel per fetch request
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int          H_ACTIVE   = 800,
  parameter int          V_ACTIVE   = 600,
  parameter int          C_BITS     = 8,
  parameter int          CHK_LOG2   = 5,
  parameter int          GRAD_SHIFT = 2,
  parameter logic [23:0] SOLID_RGB  = 24'hFFFF00
) (
  input  logic              clk_pixel,
  input  logic              rstn,
  input  logic [2:0]        mode,
  input  logic              frame_start,
  input  logic              fetch_next_pixel,
  output logic [C_BITS-1:0] r_o,
  output logic [C_BITS-1:0] g_o,
  output logic [C_BITS-1:0] b_o,
  output logic              valid_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);
  localparam logic [XW:0]   H_FULL = (XW+1)'(H_ACTIVE);

  logic [XW-1:0] x, x_cur, x_nxt;
  logic [YW-1:0] y, y_cur, y_nxt;
  mode_e         mode_q, mode_cur;
  cyc_e          cyc, cyc_cur, cyc_nxt;
  logic [7:0]    cnt_cur;
  // frame_cnt mod H_ACTIVE, kept incrementally so scroll needs no divider
  logic [XW-1:0] scroll_off, off_cur;

  logic [XW:0]       scroll_sum;
  logic [XW-1:0]     scroll_col, bar_col;
  logic [23:0]       bar_rgb24, rgb24;
  logic [C_BITS-1:0] grad, pix_r, pix_g, pix_b;
  logic              chk_bit, use_grad;

  // frame_start overrides the stored state so a coincident fetch sees the new frame.
  always_comb begin
    x_cur    = x;
    y_cur    = y;
    mode_cur = mode_q;
    cyc_cur  = cyc;
    cnt_cur  = frame_cnt_o;
    off_cur  = scroll_off;
    if (frame_start) begin
      x_cur    = '0;
      y_cur    = '0;
      mode_cur = mode_e'(mode);
      cyc_cur  = CYC_RED;
      cnt_cur  = frame_cnt_o + 8'd1;
      off_cur  = (frame_cnt_o == 8'hFF || scroll_off == X_MAX) ? '0 : scroll_off + 1'b1;
    end
  end

  always_comb begin
    x_nxt   = x_cur;
    y_nxt   = y_cur;
    cyc_nxt = cyc_cur;
    if (fetch_next_pixel) begin
      if (x_cur == X_MAX) begin
        x_nxt = '0;
        y_nxt = (y_cur == Y_MAX) ? '0 : y_cur + 1'b1;
      end else begin
        x_nxt = x_cur + 1'b1;
      end
      case (cyc_cur)
        CYC_RED:   cyc_nxt = CYC_GREEN;
        CYC_GREEN: cyc_nxt = CYC_BLUE;
        default:   cyc_nxt = CYC_RED;
      endcase
    end
  end

  // Both operands are below H_ACTIVE, so one conditional subtract is enough.
  always_comb begin
    scroll_sum = {1'b0, x_cur} + {1'b0, off_cur};
    scroll_col = (scroll_sum >= H_FULL) ? XW'(scroll_sum - H_FULL) : scroll_sum[XW-1:0];
    bar_col    = (mode_cur == MODE_SCROLL) ? scroll_col : x_cur;
  end

  pattern_gen_bars #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_bars (
    .col (bar_col),
    .rgb (bar_rgb24)
  );

  assign chk_bit = 1'(x_cur >> CHK_LOG2) ^ 1'(y_cur >> CHK_LOG2);
  assign grad    = C_BITS'({{C_BITS{1'b0}}, x_cur} >> GRAD_SHIFT);

  always_comb begin
    rgb24    = RGB_BLACK;
    use_grad = 1'b0;
    case (mode_cur)
      MODE_SOLID: rgb24 = SOLID_RGB;
      MODE_CYCLE: begin
        case (cyc_cur)
          CYC_GREEN: rgb24 = RGB_GREEN;
          CYC_BLUE:  rgb24 = RGB_BLUE;
          default:   rgb24 = RGB_RED;
        endcase
      end
      MODE_BARS, MODE_SCROLL: rgb24 = bar_rgb24;
      MODE_CHECKER:           rgb24 = chk_bit ? RGB_WHITE : RGB_BLACK;
      MODE_GRADIENT:          use_grad = 1'b1;
      default:                rgb24 = RGB_BLACK;
    endcase
    pix_r = use_grad ? grad : rgb24[23 -: C_BITS];
    pix_g = use_grad ? grad : rgb24[15 -: C_BITS];
    pix_b = use_grad ? grad : rgb24[7 -: C_BITS];
  end

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      x           <= '0;
      y           <= '0;
      mode_q      <= MODE_SOLID;
      cyc         <= CYC_RED;
      frame_cnt_o <= '0;
      scroll_off  <= '0;
      r_o         <= '0;
      g_o         <= '0;
      b_o         <= '0;
      valid_o     <= 1'b0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      mode_q      <= mode_cur;
      cyc         <= cyc_nxt;
      frame_cnt_o <= cnt_cur;
      scroll_off  <= off_cur;
      valid_o     <= fetch_next_pixel;
      if (fetch_next_pixel) begin
        r_o <= pix_r;
        g_o <= pix_g;
        b_o <= pix_b;
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - directed and random checks of pattern_gen against a behavioural model
module tb_pattern_gen;

  localparam int H = 800;
  localparam int V = 600;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] mode;
  logic       frame_start;
  logic       fetch;
  logic [7:0] r, g, b;
  logic       valid;
  logic [7:0] fcnt;

  int passed = 0;
  int total  = 0;

  int mx, my, mmode, mcyc, mcnt;
  logic [23:0] last_rgb;

  pattern_gen #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .C_BITS     (8),
    .CHK_LOG2   (5),
    .GRAD_SHIFT (2),
    .SOLID_RGB  (24'hFFFF00)
  ) dut (
    .clk_pixel        (clk),
    .rstn             (rstn),
    .mode             (mode),
    .frame_start      (frame_start),
    .fetch_next_pixel (fetch),
    .r_o              (r),
    .g_o              (g),
    .b_o              (b),
    .valid_o          (valid),
    .frame_cnt_o      (fcnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] bar_colour(input int col);
    int idx;
    idx = col / (H / 8);
    if (idx > 7) idx = 7;
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] ref_pix(input int md, input int px, input int py,
                                          input int cnt, input int cy);
    logic [7:0] gv;
    case (md)
      0: return 24'hFFFF00;
      1: return (cy == 0) ? 24'hFF0000 : (cy == 1) ? 24'h00FF00 : 24'h0000FF;
      2: return bar_colour(px);
      3: return ((((px / 32) ^ (py / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      4: begin
        gv = 8'((px / 4) % 256);
        return {gv, gv, gv};
      end
      5: return bar_colour((px + cnt) % H);
      default: return 24'h000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mmode = 0; mcyc = 0; mcnt = 0;
    last_rgb = 24'h0;
  endtask

  // One clock: drive at negedge, update the model, sample 1 time unit after posedge.
  task automatic step(input bit fs, input bit fe, input logic [2:0] md);
    logic [23:0] exp_rgb;
    int px, py;
    @(negedge clk);
    frame_start = fs;
    fetch       = fe;
    mode        = md;
    if (fs) begin
      mx = 0; my = 0; mmode = int'(md); mcyc = 0; mcnt = (mcnt + 1) % 256;
    end
    px = mx; py = my;
    exp_rgb = last_rgb;
    if (fe) begin
      exp_rgb = ref_pix(mmode, mx, my, mcnt, mcyc);
      mcyc = (mcyc + 1) % 3;
      mx = mx + 1;
      if (mx == H) begin
        mx = 0;
        my = (my + 1) % V;
      end
    end
    @(posedge clk);
    #1;
    check("valid", 32'(valid), 32'(fe));
    check($sformatf("pixel(%0d,%0d,m%0d)", px, py, mmode), {8'h0, r, g, b}, {8'h0, exp_rgb});
    check("frame_cnt", 32'(fcnt), 32'(mcnt));
    last_rgb = exp_rgb;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rgb"}, {8'h0, r, g, b}, 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_fcnt"}, 32'(fcnt), 32'h0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    frame_start = 1'b0;
    fetch       = 1'b0;
    rstn        = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; mode = 3'd0; frame_start = 1'b0; fetch = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("por");
    rstn = 1'b1;

    // Start a bars frame, then reset mid-frame; first fetch after release is (0,0) in mode 0.
    step(1'b1, 1'b0, 3'd2);
    repeat (37) step(1'b0, 1'b1, 3'd2);
    async_reset();
    step(1'b0, 1'b1, 3'd3);
    check("post_reset_solid", {8'h0, r, g, b}, 32'hFFFF00);

    // Colour cycle
    step(1'b1, 1'b0, 3'd1);
    step(1'b0, 1'b1, 3'd1);
    check("cycle_red", {8'h0, r, g, b}, 32'hFF0000);
    step(1'b0, 1'b1, 3'd1);
    check("cycle_green", {8'h0, r, g, b}, 32'h00FF00);
    step(1'b0, 1'b1, 3'd1);
    check("cycle_blue", {8'h0, r, g, b}, 32'h0000FF);
    step(1'b0, 1'b0, 3'd1);
    step(1'b0, 1'b1, 3'd1);
    check("cycle_red_again", {8'h0, r, g, b}, 32'hFF0000);

    // Bars over one full line, with the mode input wiggling mid-frame
    step(1'b1, 1'b0, 3'd2);
    for (int i = 0; i < H; i++) begin
      step(1'b0, 1'b1, 3'($urandom_range(0, 7)));
      if (i == 0 || i == 99) check("bars_white", {8'h0, r, g, b}, 32'hFFFFFF);
      if (i == 100 || i == 199) check("bars_yellow", {8'h0, r, g, b}, 32'hFFFF00);
      if (i == 700 || i == 799) check("bars_black", {8'h0, r, g, b}, 32'h000000);
    end
    check("bars_model_y", 32'(my), 32'd1);

    // Checker: scan 32 full lines, then probe line 32
    step(1'b1, 1'b0, 3'd3);
    for (int i = 0; i < 32 * H; i++) step(1'b0, 1'b1, 3'($urandom_range(0, 7)));
    for (int i = 0; i <= 32; i++) begin
      step(1'b0, 1'b1, 3'd0);
      if (i == 0) check("checker_y32_x0", {8'h0, r, g, b}, 32'hFFFFFF);
      if (i == 32) check("checker_y32_x32", {8'h0, r, g, b}, 32'h000000);
    end
    for (int i = 33; i < 417; i++) step(1'b0, 1'b1, 3'd5);

    // Collision at x=417: pixel (0,0) in gradient mode, then x continues from 1
    step(1'b1, 1'b1, 3'd4);
    check("collision_pixel", {8'h0, r, g, b}, 32'h000000);
    for (int i = 1; i < H; i++) begin
      step(1'b0, 1'b1, 3'd1);
      if (i == 4) check("gradient_x4", {8'h0, r, g, b}, 32'h010101);
      if (i == 799) check("gradient_x799", {8'h0, r, g, b}, 32'hC7C7C7);
    end

    // Scroll after exactly 100 frame starts from reset, then frame counter wrap
    async_reset();
    for (int i = 0; i < 99; i++) step(1'b1, 1'b0, 3'($urandom_range(0, 7)));
    step(1'b1, 1'b0, 3'd5);
    step(1'b0, 1'b1, 3'd5);
    check("scroll_x0_yellow", {8'h0, r, g, b}, 32'hFFFF00);
    check("scroll_fcnt100", 32'(fcnt), 32'd100);
    for (int i = 0; i < 155; i++) step(1'b1, 1'b0, 3'd5);
    check("fcnt_255", 32'(fcnt), 32'd255);
    step(1'b1, 1'b1, 3'd5);
    check("fcnt_wrap", 32'(fcnt), 32'd0);
    check("scroll_wrap_white", {8'h0, r, g, b}, 32'hFFFFFF);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
